align_shifter_pipe: RTL

- Parametrised, pipelined right/left barrel shifter for the floating-point adder datapath.
- Right mode aligns the smaller-exponent mantissa by the exponent difference and produces guard/round/sticky bits.
- Left mode normalises post-add results, with zero-fill.
- One pipeline register per shift layer. Valid/ready handshake on both sides. A sideband tag travels with the data.

---
 rtl/fp_align_pkg.sv | 30 +++
 rtl/align_shift_stage.sv | 88 ++++++++
 rtl/align_shifter_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/fp_align_pkg.sv
// Shared definitions for the FP-adder alignment/normalisation shifter.
// ALIGN_STICKY_EN widens the datapath by guard/round bits and enables sticky tracking.
package fp_align_pkg;

  localparam int MANT_W_DEF  = 11;
  localparam int SHAMT_W_DEF = 5;
  localparam int TAG_W_DEF   = 4;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Extra low-order bits carried below the mantissa ({guard, round}) when enabled.
`ifdef ALIGN_STICKY_EN
  localparam int GRS_W = 2;
`else
  localparam int GRS_W = 0;
`endif

  localparam int DATA_W_DEF = MANT_W_DEF + GRS_W;

  // Per-stage payload layout for the default configuration.
  typedef struct packed {
    logic [DATA_W_DEF-1:0]  mant_ext;
    logic                   dir;
    logic [SHAMT_W_DEF-1:0] shamt;
    logic                   sticky;
    logic [TAG_W_DEF-1:0]   tag;
  } stage_payload_t;

endpackage

// File: rtl/align_shift_stage.sv
// One shifter layer (shift by 2^STAGE) plus its pipeline register and ready logic.
// ALIGN_STICKY_EN: right shifts OR the bits falling off the bottom into the running sticky.
module align_shift_stage
  import fp_align_pkg::*;
#(
  parameter int STAGE   = 0,
  parameter int DW      = 11,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic               in_dir,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_sticky,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_dir,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_sticky,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int SHIFT = 1 << STAGE;

  typedef struct packed {
    logic [DW-1:0]      data;
    logic               dir;
    logic [SHAMT_W-1:0] shamt;
    logic               sticky;
    logic [TAG_W-1:0]   tag;
  } payload_t;

  payload_t nxt;
  payload_t q;
  logic     valid_q;

`ifdef ALIGN_STICKY_EN
  // Bits that fall below the round position when shifting right by SHIFT.
  localparam logic [DW-1:0] LOW_MASK = ~({DW{1'b1}} << SHIFT);
`endif

  always_comb begin
    nxt.data   = in_data;
    nxt.dir    = in_dir;
    nxt.shamt  = in_shamt;
    nxt.sticky = in_sticky;
    nxt.tag    = in_tag;
    if (in_shamt[STAGE]) begin
      if (in_dir == DIR_LEFT) begin
        nxt.data = in_data << SHIFT;
      end else if (in_dir == DIR_RIGHT) begin
        nxt.data = in_data >> SHIFT;
`ifdef ALIGN_STICKY_EN
        nxt.sticky = in_sticky | (|(in_data & LOW_MASK));
`endif
      end
    end
  end

  // A stage may accept whenever it is empty or its occupant is leaving this cycle.
  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        q <= nxt;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = q.data;
  assign out_dir    = q.dir;
  assign out_shamt  = q.shamt;
  assign out_sticky = q.sticky;
  assign out_tag    = q.tag;

endmodule

// File: rtl/align_shifter_pipe.sv
// Pipelined right-align / left-normalise barrel shifter, one register per shift layer.
// ALIGN_STICKY_EN: carries guard/round bits and a sticky bit in right mode; otherwise GRS are 0.
module align_shifter_pipe
  import fp_align_pkg::*;
#(
  parameter int MANT_W  = MANT_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_dir,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  out_mant,
  output logic               out_guard,
  output logic               out_round,
  output logic               out_sticky,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int DW = MANT_W + GRS_W;

  logic [SHAMT_W:0]   valid;
  logic [SHAMT_W:0]   ready;
  logic [DW-1:0]      data   [SHAMT_W+1];
  logic               dir    [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt  [SHAMT_W+1];
  logic               sticky [SHAMT_W+1];
  logic [TAG_W-1:0]   tag    [SHAMT_W+1];

  assign valid[0]  = in_valid;
  assign in_ready  = ready[0];
  assign dir[0]    = in_dir;
  assign shamt[0]  = in_shamt;
  assign sticky[0] = 1'b0;
  assign tag[0]    = in_tag;

`ifdef ALIGN_STICKY_EN
  assign data[0] = {in_mant, 2'b00};
`else
  assign data[0] = in_mant;
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    align_shift_stage #(
      .STAGE  (k),
      .DW     (DW),
      .SHAMT_W(SHAMT_W),
      .TAG_W  (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid[k]),
      .in_ready  (ready[k]),
      .in_data   (data[k]),
      .in_dir    (dir[k]),
      .in_shamt  (shamt[k]),
      .in_sticky (sticky[k]),
      .in_tag    (tag[k]),
      .out_valid (valid[k+1]),
      .out_ready (ready[k+1]),
      .out_data  (data[k+1]),
      .out_dir   (dir[k+1]),
      .out_shamt (shamt[k+1]),
      .out_sticky(sticky[k+1]),
      .out_tag   (tag[k+1])
    );
  end

  assign ready[SHAMT_W] = out_ready;
  assign out_valid      = valid[SHAMT_W];
  assign out_mant       = data[SHAMT_W][DW-1 -: MANT_W];
  assign out_tag        = tag[SHAMT_W];

`ifdef ALIGN_STICKY_EN
  assign out_guard  = data[SHAMT_W][1];
  assign out_round  = data[SHAMT_W][0];
  assign out_sticky = sticky[SHAMT_W];
`else
  assign out_guard  = 1'b0;
  assign out_round  = 1'b0;
  assign out_sticky = 1'b0;
`endif

  // Control fields are fully consumed by the last layer.
  logic unused_tail;
  assign unused_tail = ^{shamt[SHAMT_W], dir[SHAMT_W], sticky[SHAMT_W]};

endmodule
